// File: rtl/matrix_bcm.sv
// matrix_bcm: HUB75 scan driver with binary-code-modulated bit-planes and a double-buffered frame RAM.
// Optional MATRIX_BRIGHTNESS_EN adds a global brightness input that trims each on-window.
module matrix_bcm #(
  parameter int DIVIDER   = 3,
  parameter int LENGTH    = 64,
  parameter int BITDEPTH  = 8,
  parameter int SCAN_BITS = 4,
  parameter int LANES     = 2,
  parameter int UNIT      = 8,
  parameter int BLANK     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_b,
  output logic [$clog2(LENGTH<<SCAN_BITS)-1:0] addr,
  output logic                                 bank,
  input  logic [LANES*3*BITDEPTH-1:0]          data,
  output logic [LANES*3-1:0]                   rgb,
  output logic                                 sclk,
  output logic                                 latch,
  output logic                                 oe_b,
  output logic [SCAN_BITS-1:0]                 select,
  input  logic                                 swap_req,
  output logic                                 swap_ack,
  output logic                                 frame_start
`ifdef MATRIX_BRIGHTNESS_EN
  ,
  input  logic [7:0]                           brightness
`endif
);

  // state   | meaning
  // SHIFT   | shifting plane n while plane n-1 (if any) is displayed
  // WAIT    | shift done, on-timer still running
  // LATCH   | one sclk period with latch=1, oe_b=1, sclk low
  // BLANK   | BLANK clocks of oe_b=1 after a row-select change
  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  localparam int AW   = $clog2(LENGTH << SCAN_BITS);
  localparam int CW   = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;
  localparam int LW   = $clog2(LENGTH);
  localparam int PW   = (BITDEPTH > 1) ? $clog2(BITDEPTH) : 1;
  localparam int TW   = $clog2((UNIT << (BITDEPTH - 1)) + 1);
  localparam int GW   = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int RISE = DIVIDER / 2 + 1;

  logic [1:0]           state, state_n;
  logic [CW-1:0]        cyc, cyc_n;
  logic [LW-1:0]        col, col_n;
  logic [SCAN_BITS-1:0] row, row_nx;
  logic [PW-1:0]        plane, plane_nx, lat_plane;
  logic [TW-1:0]        timer, timer_n, on_cnt, on_cnt_n, win, on_win;
  logic [GW-1:0]        gap, gap_n;
  logic                 row_chg, shift_end, on_last, last_plane, start_shift, enter_latch;
  logic [AW-1:0]        addr_nx;
  logic [LANES*3-1:0]   rgb_nx;

  // Each output bit picks bit 'plane' of its colour field.
  for (genvar gi = 0; gi < LANES * 3; gi++) begin : g_bit
    logic [BITDEPTH-1:0] px;
    assign px         = data[gi*BITDEPTH +: BITDEPTH];
    assign rgb_nx[gi] = px[plane];
  end

`ifdef MATRIX_BRIGHTNESS_EN
  logic [7:0] bri_q;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)         bri_q <= 8'd0;
    else if (enter_latch) bri_q <= brightness;
  end
  assign on_win = TW'((32'(win) * (32'(bri_q) + 32'd1)) >> 8);
`else
  assign on_win = win;
`endif

  always_comb begin
    last_plane = (plane == PW'(BITDEPTH - 1));
    row_nx     = last_plane ? row + 1'b1 : row;
    plane_nx   = last_plane ? '0 : plane + 1'b1;
    shift_end  = (col == LW'(LENGTH - 1)) && (cyc == CW'(DIVIDER));
    // Leaving at timer==1 makes the last on-clock coincide with the last wait clock.
    on_last    = (timer <= TW'(1));
    win        = TW'(UNIT) << lat_plane;
    if (col == LW'(LENGTH - 1)) addr_nx = AW'(int'(row_nx) * LENGTH);
    else                        addr_nx = AW'(int'(row) * LENGTH + int'(col) + 1);
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    col_n       = col;
    gap_n       = gap;
    start_shift = 1'b0;
    timer_n     = (timer != '0) ? timer - 1'b1 : '0;
    on_cnt_n    = (on_cnt != '0) ? on_cnt - 1'b1 : '0;
    case (state)
      S_SHIFT: begin
        if (shift_end) begin
          cyc_n   = '0;
          state_n = on_last ? S_LATCH : S_WAIT;
        end else if (cyc == CW'(DIVIDER)) begin
          cyc_n = '0;
          col_n = col + 1'b1;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      S_WAIT: if (on_last) state_n = S_LATCH;
      S_LATCH: begin
        if (cyc == CW'(DIVIDER)) begin
          cyc_n = '0;
          if (row_chg && BLANK > 0) begin
            state_n = S_BLANK;
            gap_n   = GW'(BLANK - 1);
          end else begin
            start_shift = 1'b1;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: begin
        if (gap == '0) start_shift = 1'b1;
        else           gap_n = gap - 1'b1;
      end
    endcase
    if (start_shift) begin
      state_n  = S_SHIFT;
      col_n    = '0;
      timer_n  = win;
      on_cnt_n = on_win;
    end
    enter_latch = (state_n == S_LATCH) && (state != S_LATCH);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= S_SHIFT;
      cyc         <= '0;
      col         <= '0;
      row         <= '0;
      plane       <= '0;
      lat_plane   <= '0;
      timer       <= '0;
      on_cnt      <= '0;
      gap         <= '0;
      row_chg     <= 1'b0;
      addr        <= '0;
      bank        <= 1'b0;
      rgb         <= '0;
      sclk        <= 1'b0;
      latch       <= 1'b0;
      oe_b        <= 1'b1;
      select      <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cyc         <= cyc_n;
      col         <= col_n;
      timer       <= timer_n;
      on_cnt      <= on_cnt_n;
      gap         <= gap_n;
      sclk        <= (state_n == S_SHIFT) && (cyc_n >= CW'(RISE));
      latch       <= (state_n == S_LATCH);
      oe_b        <= (on_cnt_n == '0);
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      // Capture this column and prefetch the next, so rgb settles a clock before sclk rises.
      if (state == S_SHIFT && cyc == '0) begin
        rgb  <= rgb_nx;
        addr <= addr_nx;
      end
      if (enter_latch) begin
        lat_plane   <= plane;
        plane       <= plane_nx;
        row         <= row_nx;
        frame_start <= (row == '0) && (plane == '0);
        row_chg     <= (plane == '0) && (row != select);
        if (plane == '0) select <= row;
        if (last_plane && (row == '1) && swap_req) begin
          bank     <= ~bank;
          swap_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_bcm.sv
// Directed bench for matrix_bcm with a small panel (4 columns, 2 rows, 2 planes, 2 lanes).
module tb_matrix_bcm;
  localparam int DIVIDER = 3, LENGTH = 4, BITDEPTH = 2, SCAN_BITS = 1;
  localparam int LANES = 2, UNIT = 8, BLANK = 2;
  localparam int AW = $clog2(LENGTH << SCAN_BITS);
  localparam int DW = LANES * 3 * BITDEPTH;
  // bank 0: lane0 R=10, lane1 B=01; bank 1: lane0 G=11
  localparam logic [DW-1:0] WORD0 = 12'b01_00_00_00_00_10;
  localparam logic [DW-1:0] WORD1 = 12'b00_00_00_00_11_00;

  logic                 clk, reset_b, bank, sclk, latch, oe_b, swap_req, swap_ack, frame_start;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        data;
  logic [LANES*3-1:0]   rgb;
  logic [SCAN_BITS-1:0] select;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [7:0]           brightness;
`endif

  int checks = 0;
  int failures = 0;

  matrix_bcm #(
    .DIVIDER(DIVIDER), .LENGTH(LENGTH), .BITDEPTH(BITDEPTH), .SCAN_BITS(SCAN_BITS),
    .LANES(LANES), .UNIT(UNIT), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset_b(reset_b), .addr(addr), .bank(bank), .data(data), .rgb(rgb),
    .sclk(sclk), .latch(latch), .oe_b(oe_b), .select(select), .swap_req(swap_req),
    .swap_ack(swap_ack), .frame_start(frame_start)
`ifdef MATRIX_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) data <= bank ? WORD1 : WORD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    int n, rises;
    logic prev;
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oe_b !== 1'b1) begin failures++; $display("FAIL reset_oe_b: got %b expected 1", oe_b); end
    checks++; if (addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    checks++; if (rgb !== '0) begin failures++; $display("FAIL reset_rgb: got %b expected 0", rgb); end
    checks++;
    if ({bank, sclk, latch, select, swap_ack, frame_start} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bank, sclk, latch, select, swap_ack, frame_start});
    end
    @(negedge clk);
    reset_b = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sclk) begin n = i; break; end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL first_sclk_rise: got %0d clocks expected 2", n); end
    rises = 1; prev = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sclk && !prev) rises++;
      prev = sclk;
      if (latch) break;
    end
    checks++; if (rises != 4) begin failures++; $display("FAIL rises_before_latch: got %0d expected 4", rises); end
    checks++; if (latch !== 1'b1 || frame_start !== 1'b1) begin
      failures++; $display("FAIL first_latch_frame_start: got latch=%b fs=%b expected 1 1", latch, frame_start);
    end
  endtask

  task automatic test_bitplane();
    int rises, exp_addr;
    logic prev;
    logic [5:0] exp_rgb;
    apply_reset();
    rises = 0; prev = 1'b0;
    for (int t = 0; t < 60 && rises < 8; t++) begin
      step();
      if (sclk && !prev) begin
        exp_rgb  = (rises < 4) ? 6'b100000 : 6'b000001;
        exp_addr = (rises < 7) ? (rises + 1) % 4 : 4;
        checks++; if (rgb !== exp_rgb) begin
          failures++; $display("FAIL plane_rgb[%0d]: got %b expected %b", rises, rgb, exp_rgb);
        end
        checks++; if (int'(addr) != exp_addr) begin
          failures++; $display("FAIL prefetch_addr[%0d]: got %0d expected %0d", rises, addr, exp_addr);
        end
        rises++;
      end
      prev = sclk;
    end
    checks++; if (rises != 8) begin failures++; $display("FAIL plane_rises: got %0d expected 8", rises); end
  endtask

  task automatic test_bcm();
    int runs[4];
    int nrun, len, bad;
    logic [SCAN_BITS-1:0] prev_sel;
    apply_reset();
    nrun = 0; len = 0; bad = 0; prev_sel = select;
    for (int i = 0; i < 4; i++) runs[i] = 0;
    for (int t = 1; t <= 140 && nrun < 4; t++) begin
      step();
      if (!oe_b) begin
        len++;
        if (latch) bad++;
      end else if (len != 0) begin
        runs[nrun] = len; nrun++; len = 0;
      end
      if (select !== prev_sel && !latch) bad++;
      prev_sel = select;
    end
    checks++; if (nrun != 4) begin failures++; $display("FAIL bcm_windows: got %0d expected 4", nrun); end
    checks++; if (runs[0] != 8) begin failures++; $display("FAIL bcm_p0_r0: got %0d expected 8", runs[0]); end
    checks++; if (runs[1] != 16) begin failures++; $display("FAIL bcm_p1_r0: got %0d expected 16", runs[1]); end
    checks++; if (runs[2] != 8) begin failures++; $display("FAIL bcm_p0_r1: got %0d expected 8", runs[2]); end
    checks++; if (runs[3] != 16) begin failures++; $display("FAIL bcm_p1_r1: got %0d expected 16", runs[3]); end
    checks++; if (bad != 0) begin failures++; $display("FAIL bcm_overlap: got %0d violations expected 0", bad); end
  endtask

  task automatic test_row_change();
    int nl, done, gapc;
    int gaps[4];
    logic [SCAN_BITS-1:0] sels[4];
    logic prev_latch, counting;
    int exp_gap[4];
    logic [SCAN_BITS-1:0] exp_sel[4];
    exp_gap = '{0, 0, 2, 0};
    exp_sel = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    nl = 0; done = 0; gapc = 0; prev_latch = 1'b0; counting = 1'b0;
    for (int i = 0; i < 4; i++) begin gaps[i] = -1; sels[i] = 'x; end
    for (int t = 0; t < 120 && done < 4; t++) begin
      step();
      if (latch && !prev_latch && nl < 4) begin sels[nl] = select; nl++; end
      if (!latch && prev_latch) begin counting = 1'b1; gapc = 0; end
      if (counting) begin
        if (oe_b) gapc++;
        else begin gaps[nl-1] = gapc; counting = 1'b0; done++; end
      end
      prev_latch = latch;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sels[i] !== exp_sel[i]) begin
        failures++; $display("FAIL latch_select[%0d]: got %b expected %b", i, sels[i], exp_sel[i]);
      end
      checks++; if (gaps[i] != exp_gap[i]) begin
        failures++; $display("FAIL blank_clocks[%0d]: got %0d expected %0d", i, gaps[i], exp_gap[i]);
      end
    end
  endtask

  task automatic test_swap();
    int nl, early;
    logic found, prev_latch, prev_sclk;
    apply_reset();
    swap_req = 1'b1;
    nl = 0; early = 0; found = 1'b0; prev_latch = 1'b0;
    for (int t = 0; t < 200; t++) begin
      step();
      if (latch && !prev_latch) nl++;
      prev_latch = latch;
      if (swap_ack) begin found = 1'b1; break; end
      if (bank !== 1'b0) early++;
    end
    checks++; if (!found) begin failures++; $display("FAIL swap_ack_seen: got 0 expected 1"); end
    checks++; if (nl != 4) begin failures++; $display("FAIL swap_at_latch: got latch #%0d expected 4", nl); end
    checks++; if (early != 0) begin failures++; $display("FAIL bank_early: got %0d clocks expected 0", early); end
    checks++; if (bank !== 1'b1 || addr !== '0 || latch !== 1'b1) begin
      failures++; $display("FAIL swap_state: got bank=%b addr=%0d latch=%b expected 1 0 1", bank, addr, latch);
    end
    swap_req = 1'b0;
    step();
    checks++; if (swap_ack !== 1'b0 || bank !== 1'b1) begin
      failures++; $display("FAIL swap_pulse: got ack=%b bank=%b expected 0 1", swap_ack, bank);
    end
    prev_sclk = sclk; found = 1'b0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (sclk && !prev_sclk) begin found = 1'b1; break; end
      prev_sclk = sclk;
    end
    checks++; if (!found || rgb !== 6'b000010) begin
      failures++; $display("FAIL new_bank_rgb: got %b expected 000010", rgb);
    end
    found = 1'b0;
    for (int t = 0; t < 60; t++) begin
      step();
      if (latch && !prev_latch) begin found = 1'b1; break; end
      prev_latch = latch;
    end
    checks++; if (!found || frame_start !== 1'b1 || select !== '0) begin
      failures++; $display("FAIL frame_start_after_swap: got fs=%b sel=%b expected 1 0", frame_start, select);
    end
  endtask

  task automatic test_reset_mid();
    int n, rises;
    logic found, prev;
    apply_reset();
    found = 1'b0;
    for (int t = 0; t < 60; t++) begin
      step();
      if (!oe_b) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_oe_low_seen: got 0 expected 1"); end
    #2;
    reset_b = 1'b0;
    #1;
    checks++; if (oe_b !== 1'b1) begin failures++; $display("FAIL async_oe_b: got %b expected 1", oe_b); end
    checks++; if ({sclk, latch} !== 2'b00) begin
      failures++; $display("FAIL async_ctrl: got %b expected 00", {sclk, latch});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sclk) begin n = i; break; end
    end
    checks++; if (n != 2 || rgb !== 6'b100000 || addr !== AW'(1)) begin
      failures++; $display("FAIL restart_first_col: got clk=%0d rgb=%b addr=%0d expected 2 100000 1", n, rgb, addr);
    end
    rises = 1; prev = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sclk && !prev) rises++;
      prev = sclk;
      if (latch) break;
    end
    checks++; if (rises != 4 || frame_start !== 1'b1) begin
      failures++; $display("FAIL restart_latch: got rises=%0d fs=%b expected 4 1", rises, frame_start);
    end
  endtask

`ifdef MATRIX_BRIGHTNESS_EN
  task automatic test_brightness();
    int runs[2];
    int starts[2];
    int nrun, len;
    brightness = 8'd127;
    apply_reset();
    nrun = 0; len = 0;
    runs = '{0, 0}; starts = '{0, 0};
    for (int t = 1; t <= 80 && nrun < 2; t++) begin
      step();
      if (!oe_b) begin
        if (len == 0) starts[nrun] = t;
        len++;
      end else if (len != 0) begin
        runs[nrun] = len; nrun++; len = 0;
      end
    end
    checks++; if (runs[0] != 4 || starts[0] != 20) begin
      failures++; $display("FAIL bright_p0: got len=%0d start=%0d expected 4 20", runs[0], starts[0]);
    end
    checks++; if (runs[1] != 8 || starts[1] != 40) begin
      failures++; $display("FAIL bright_p1: got len=%0d start=%0d expected 8 40", runs[1], starts[1]);
    end
    brightness = 8'd255;
  endtask
`endif

  initial begin
    reset_b = 1'b0;
    swap_req = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    test_reset();
    test_bitplane();
    test_bcm();
    test_row_change();
    test_swap();
    test_reset_mid();
`ifdef MATRIX_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_bcm.md
# matrix_bcm

Second-generation HUB75 LED-matrix scan driver. It reads pixel words from a double-buffered frame RAM and shifts them into the panel column drivers across any number of parallel RGB lanes. Brightness uses binary-code modulation (BCM): bit-planes are displayed for weighted on-times, and the shift of the next plane overlaps display of the current one. It sits between the frame-buffer RAM and the panel connector, and hands off buffer ownership at frame boundaries.

## Interface
- DIVIDER, 3: clocks per sclk period minus 1.
- LENGTH, 64: columns shifted per row, at least 2.
- BITDEPTH, 8: bits per colour.
- SCAN_BITS, 4: width of the row select; rows = 2^SCAN_BITS.
- LANES, 2: parallel RGB lanes (HUB75 upper/lower = 2).
- UNIT, 8: clocks of on-time for plane 0; plane b gets UNIT<<b.
- BLANK, 2: clocks of oe_b high after every latch that changes select.

- clk  in  1  single clock.
- reset_b  in  1  asynchronous, active-low reset.
- addr  out  clog2(LENGTH<<SCAN_BITS)  pixel address, row*LENGTH+col.
- bank  out  1  frame-buffer bank being read (RAM address MSB).
- data  in  LANES*3*BITDEPTH  pixel word, valid 1 clock after addr; lane L colour c at [(L*3+c)*BITDEPTH +: BITDEPTH], c: 0=R, 1=G, 2=B.
- rgb  out  LANES*3  panel data, bit L*3+c.
- sclk, latch, oe_b  out  1 each  panel shift clock, latch, active-low output enable.
- select  out  SCAN_BITS  panel row address.
- swap_req  in  1  level; the producer requests a bank flip.
- swap_ack  out  1  one-clock pulse when bank flips.
- frame_start  out  1  one-clock pulse when row 0 plane 0 is latched.

## Operation
- Shifter: cycle counter 0..DIVIDER. sclk falls at count 0 and rises at DIVIDER/2+1. One column is shifted per sclk period. addr is issued so that data, registered, drives rgb before the rising edge.
- rgb[L*3+c] = bit p of pixel colour c, where p is the plane being shifted.
- Order: for row r = 0..2^SCAN_BITS-1, plane p = 0..BITDEPTH-1. After the last plane of the last row, wrap to row 0 plane 0.
- Display FSM:
  - SHIFT: shifting plane n. The plane latched earlier (n-1) is still displayed.
  - WAIT: shift is done and the on-timer is not yet expired.
  - LATCH: oe_b=1 and latch=1 for one full sclk period with sclk low. If the latched plane is plane 0 of a new row, select takes that row.
  - BLANKING: BLANK clocks with oe_b=1; entered only when select changed.
  - Then the on-timer loads UNIT<<p, oe_b goes low, and SHIFT of the next plane starts. If the timer expires first, the FSM goes to SHIFT with oe_b=1 until the shift completes.
- Transitions: SHIFT→WAIT when the shift is done and the timer is nonzero. SHIFT or WAIT→LATCH when the shift is done and the timer is zero.
- First plane after reset: shifted with oe_b=1; nothing is displayed until the first latch.
- Bank swap: sampled only in the clock where the last plane of the last row is latched.
  - If swap_req=1: bank toggles and swap_ack pulses in that same clock.
  - The next addr fetch uses the new bank.
  - bank never changes mid-frame.
- frame_start pulses in the clock where latch rises for row 0 plane 0.

## Timing
- Reset values: addr=0, bank=0, rgb=0, sclk=0, latch=0, oe_b=1, select=0, swap_ack=0, frame_start=0. The FSM starts in SHIFT, row 0, plane 0.
- Reset is asynchronous: oe_b goes high immediately, mid-shift or mid-display.
- RAM read latency: exactly 1 clock.
- Plane slot, in clocks: max(LENGTH*(DIVIDER+1), UNIT<<p) + (DIVIDER+1) latch period, plus BLANK on a row change.
- oe_b low time for plane p: exactly UNIT<<p clocks. It is never low while latch=1 or while select changes.
- Widths:
  - The on-timer is sized for UNIT<<(BITDEPTH-1).
  - The column counter wraps at LENGTH-1.
  - The row counter wraps naturally at 2^SCAN_BITS.

## Configuration
- MATRIX_BRIGHTNESS_EN defined:
  - Adds input brightness[7:0].
  - oe_b is low for the first ((UNIT<<p)*(brightness+1))>>8 clocks of each on-window, minimum 0. The slot length is unchanged.
  - brightness is sampled once per latch.
- Not defined: no port, and oe_b is low for the full UNIT<<p.

## Test plan
Bench parameters: LENGTH=4, SCAN_BITS=1, BITDEPTH=2, LANES=2, DIVIDER=3, UNIT=8, BLANK=2.

- Reset: hold reset_b=0 → all outputs at their reset values. Release → the first sclk rise occurs 2 clocks later, and 4 rises precede the first latch.
- Bit-plane data: all pixels lane0 R=2'b10, lane1 B=2'b01 → during plane 0 shifts rgb=6'b100_000 (bit 5 = lane1 B). During plane 1 shifts rgb=6'b000_001.
- BCM on-time: plane 0 oe_b low exactly 8 clocks. Plane 1 oe_b low exactly 16 clocks. No latch pulse while oe_b=0.
- Row change: latch of row 1 plane 0 → select=1 during latch, then oe_b high for 2 extra clocks. Plane 1 latch → no blanking.
- Swap: assert swap_req during row 0 → bank stays 0 until row 1 plane 1 is latched, then bank=1 with a 1-clock swap_ack. Next addr=0 with bank=1. frame_start follows at the next row 0 plane 0 latch.
- Reset mid-display: drop reset_b while oe_b=0 → oe_b=1 in the same clock without waiting for an edge. After release, full restart from row 0 plane 0.
- With MATRIX_BRIGHTNESS_EN and brightness=127: plane 1 oe_b low 8 of 16 clocks.
